pc_redirect_controller: RTL and testbench

//  Owns the fetch PC register of the 5-stage MIPS pipeline and sequences next-PC selection.

---
 rtl/pc_redirect_controller.sv | 122 ++++++++++++
 tb/tb_pc_redirect_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_controller.sv
// Fetch PC register and next-PC sequencer for the 5-stage MIPS pipeline.
// Holds a redirect that arrives during a fetch stall and drives the IF/ID flush.
module pc_redirect_controller #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic        jump_valid,
    input  logic [31:0] id_pc_plus4,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_instr_idx,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_ifid,
    output logic        redirect
);

    typedef enum logic [1:0] {
        SEQ   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] target;
    logic        req;

    assign br_tgt   = id_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
    assign j_tgt    = {id_pc_plus4[31:28], id_instr_idx, 2'b00};
    assign req      = jump_valid | (branch_valid & branch_taken);
    assign target   = jump_valid ? j_tgt : br_tgt;
    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        redirect_d = 1'b0;
        case (state_q)
            SEQ: begin
                if (req && !stall) begin
                    pc_d       = target;
                    state_d    = FLUSH;
                    cnt_d      = CNT_INIT;
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                end else if (req) begin
                    pend_d  = target;
                    state_d = HOLD;
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_d       = pend_q;
                    state_d    = FLUSH;
                    cnt_d      = CNT_INIT;
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                end
            end
            FLUSH: begin
                // The squashed ID instruction cannot redirect, but sequential fetch continues.
                if (!stall) begin
                    pc_d = pc_plus4;
                end
                if (cnt_q == 3'd0) begin
                    state_d = SEQ;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = SEQ;
                flush_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ;
            pc_q       <= RESET_PC;
            pend_q     <= 32'd0;
            cnt_q      <= 3'd0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc         = pc_q;
    assign flush_ifid = flush_q;
    assign redirect   = redirect_q;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Bench for pc_redirect_controller: two instances (flush length 1 and 3) share stimulus
// and are compared every cycle against a counting model plus hand-computed literals.
module tb_pc_redirect_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_valid;
    logic        branch_taken;
    logic        jump_valid;
    logic [31:0] id_pc_plus4;
    logic [15:0] id_imm16;
    logic [25:0] id_instr_idx;

    logic [31:0] pc1, pp1, pc3, pp3;
    logic        flush1, redir1, flush3, redir3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_redirect_controller #(.RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_valid(branch_valid), .branch_taken(branch_taken), .jump_valid(jump_valid),
        .id_pc_plus4(id_pc_plus4), .id_imm16(id_imm16), .id_instr_idx(id_instr_idx),
        .pc(pc1), .pc_plus4(pp1), .flush_ifid(flush1), .redirect(redir1)
    );

    pc_redirect_controller #(.RESET_PC(32'h0), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_valid(branch_valid), .branch_taken(branch_taken), .jump_valid(jump_valid),
        .id_pc_plus4(id_pc_plus4), .id_imm16(id_imm16), .id_instr_idx(id_instr_idx),
        .pc(pc3), .pc_plus4(pp3), .flush_ifid(flush3), .redirect(redir3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pc value, an optional parked target, and the number of flush cycles still owed.
    logic [31:0] m_pc[2];
    logic [31:0] m_pend[2];
    logic        m_pend_v[2];
    int          m_flush_left[2];
    logic        m_redir[2];

    function automatic int flush_len(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] model_target();
        logic [31:0] off;
        off = {{14{id_imm16[15]}}, id_imm16, 2'b00};
        if (jump_valid)
            return {id_pc_plus4[31:28], id_instr_idx, 2'b00};
        return id_pc_plus4 + off;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pc[k]         <= 32'h0;
                m_pend[k]       <= 32'h0;
                m_pend_v[k]     <= 1'b0;
                m_flush_left[k] <= 0;
                m_redir[k]      <= 1'b0;
            end else begin
                m_redir[k] <= 1'b0;
                if (m_pend_v[k]) begin
                    if (!stall) begin
                        m_pc[k]         <= m_pend[k];
                        m_pend_v[k]     <= 1'b0;
                        m_flush_left[k] <= flush_len(k);
                        m_redir[k]      <= 1'b1;
                    end
                end else if (m_flush_left[k] != 0) begin
                    m_flush_left[k] <= m_flush_left[k] - 1;
                    if (!stall) m_pc[k] <= m_pc[k] + 32'd4;
                end else if (jump_valid || (branch_valid && branch_taken)) begin
                    if (!stall) begin
                        m_pc[k]         <= model_target();
                        m_flush_left[k] <= flush_len(k);
                        m_redir[k]      <= 1'b1;
                    end else begin
                        m_pend[k]   <= model_target();
                        m_pend_v[k] <= 1'b1;
                    end
                end else if (!stall) begin
                    m_pc[k] <= m_pc[k] + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("d1_pc",       pc1,    m_pc[0]);
        check("d1_pc_plus4", pp1,    m_pc[0] + 32'd4);
        check("d1_flush",    {31'd0, flush1}, {31'd0, m_flush_left[0] != 0});
        check("d1_redirect", {31'd0, redir1}, {31'd0, m_redir[0]});
        check("d3_pc",       pc3,    m_pc[1]);
        check("d3_pc_plus4", pp3,    m_pc[1] + 32'd4);
        check("d3_flush",    {31'd0, flush3}, {31'd0, m_flush_left[1] != 0});
        check("d3_redirect", {31'd0, redir3}, {31'd0, m_redir[1]});
    end

    task automatic cyc(input logic s, input logic bv, input logic bt, input logic jv,
                       input logic [31:0] p4, input logic [15:0] imm, input logic [25:0] idx);
        stall        = s;
        branch_valid = bv;
        branch_taken = bt;
        jump_valid   = jv;
        id_pc_plus4  = p4;
        id_imm16     = imm;
        id_instr_idx = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0; jump_valid = 1'b0;
        id_pc_plus4 = 32'h0; id_imm16 = 16'h0; id_instr_idx = 26'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("lit_reset_pc", pc1, 32'h0);
        idle(1);
        check("lit_seq_pc4", pc1, 32'h4);
        idle(1);
        check("lit_seq_pc8", pc1, 32'h8);

        // Asynchronous reset while both instances are flushing after a jump.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 16'h0, 26'h100);
        check("lit_jump_pre_reset", pc1, 32'h1000_0400);
        check("lit_d3_flush_pre_reset", {31'd0, flush3}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("lit_async_pc1", pc1, 32'h0);
        check("lit_async_pc3", pc3, 32'h0);
        check("lit_async_flush3", {31'd0, flush3}, 32'd0);
        check("lit_async_redir1", {31'd0, redir1}, 32'd0);
        stall = 1'b0; jump_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("lit_post_reset_pc", pc1, 32'h0);
        idle(1);
        idle(1);

        // Taken backward branch; d3 must hold flush exactly three cycles.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 16'hFFFF, 26'h0);
        check("lit_br_pc", pc1, 32'h0FC);
        check("lit_br_flush1", {31'd0, flush1}, 32'd1);
        check("lit_br_redir1", {31'd0, redir1}, 32'd1);
        check("lit_br_flush3_c1", {31'd0, flush3}, 32'd1);
        idle(1);
        check("lit_br_next_pc", pc1, 32'h100);
        check("lit_br_flush1_drop", {31'd0, flush1}, 32'd0);
        check("lit_br_redir1_drop", {31'd0, redir1}, 32'd0);
        check("lit_br_flush3_c2", {31'd0, flush3}, 32'd1);
        idle(1);
        check("lit_br_flush3_c3", {31'd0, flush3}, 32'd1);
        idle(1);
        check("lit_br_flush3_drop", {31'd0, flush3}, 32'd0);

        // Not-taken branch advances sequentially.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 16'h0010, 26'h0);
        check("lit_nt_pc", pc1, 32'h10C);
        check("lit_nt_flush", {31'd0, flush1}, 32'd0);
        check("lit_nt_redir", {31'd0, redir1}, 32'd0);

        // Jump and taken branch together: jump wins.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0010, 16'h0008, 26'h0000040);
        check("lit_jump_pc1", pc1, 32'hA000_0100);
        check("lit_jump_pc3", pc3, 32'hA000_0100);
        check("lit_jump_redir", {31'd0, redir1}, 32'd1);
        idle(3);

        // Redirect under a three-cycle stall; the second request is ignored.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 16'h0004, 26'h0);
        check("lit_hold_pc_c1", pc1, 32'hA000_010C);
        check("lit_hold_flush_c1", {31'd0, flush1}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 16'h0, 26'h55);
        check("lit_hold_pc_c2", pc1, 32'hA000_010C);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        check("lit_hold_pc_c3", pc1, 32'hA000_010C);
        check("lit_hold_flush_c3", {31'd0, flush1}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 16'h0, 26'h77);
        check("lit_hold_release_pc", pc1, 32'h210);
        check("lit_hold_release_redir", {31'd0, redir1}, 32'd1);
        check("lit_hold_release_flush", {31'd0, flush1}, 32'd1);
        idle(3);

        // Wrap-around of sequential fetch and of the branch adder.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 16'h0, 26'h3FF_FFFF);
        check("lit_top_pc", pc1, 32'hFFFF_FFFC);
        check("lit_top_pc_plus4", pp1, 32'h0);
        idle(1);
        check("lit_wrap_pc", pc1, 32'h0);
        idle(3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 16'hFFFE, 26'h0);
        check("lit_br_wrap_pc", pc1, 32'hFFFF_FFFC);
        // Stall during the flush cycle: pc held, flush still ends on time.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        check("lit_flush_stall_pc", pc1, 32'hFFFF_FFFC);
        check("lit_flush_stall_drop", {31'd0, flush1}, 32'd0);
        idle(4);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
